// File: rtl/divider_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : divider_arbiter_ctrl
// Description : Two-client round-robin arbiter and sequencer for a shared
//               sequential divider (clear, run, capture, respond).
// Revision    : 1.0 - initial release
// ============================================================================
module divider_arbiter_ctrl #(
    parameter int C_NUM_BITS   = 4,
    parameter int C_DIV_CYCLES = 8
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic [1:0]            REQ_VALID,
    output logic [1:0]            REQ_READY,
    input  logic [C_NUM_BITS-1:0] REQ_A0,
    input  logic [C_NUM_BITS-1:0] REQ_B0,
    input  logic [C_NUM_BITS-1:0] REQ_A1,
    input  logic [C_NUM_BITS-1:0] REQ_B1,
    output logic [1:0]            RSP_VALID,
    output logic [C_NUM_BITS-1:0] RSP_Q,
    output logic [C_NUM_BITS-1:0] RSP_R,
    output logic                  RSP_DZ,
    output logic                  BUSY,
    output logic                  DIV_E,
    output logic                  DIV_RN,
    output logic [C_NUM_BITS-1:0] DIV_A,
    output logic [C_NUM_BITS-1:0] DIV_B,
    input  logic [C_NUM_BITS-1:0] DIV_Q,
    input  logic [C_NUM_BITS-1:0] DIV_R
);

    localparam int CNT_W = $clog2(C_DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(C_DIV_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_last;
    logic                  r_owner;
    logic [C_NUM_BITS-1:0] r_div_a;
    logic [C_NUM_BITS-1:0] r_div_b;
    logic [C_NUM_BITS-1:0] r_rsp_q;
    logic [C_NUM_BITS-1:0] r_rsp_r;
    logic                  r_rsp_dz;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic [C_NUM_BITS-1:0] w_sel_a;
    logic [C_NUM_BITS-1:0] w_sel_b;

    assign w_sel_a = w_grant[1] ? REQ_A1 : REQ_A0;
    assign w_sel_b = w_grant[1] ? REQ_B1 : REQ_B0;

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_sel_b == '0) ? S_RESP : S_CLEAR;
                end
            end
            S_CLEAR: w_next = S_RUN;
            S_RUN: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ties go to the client that was not granted last; r_last=1 favours client 0.
    always_comb begin
        w_grant   = 2'b00;
        REQ_READY = 2'b00;
        BUSY      = (r_state != S_IDLE);
        DIV_E     = (r_state == S_CLEAR) || (r_state == S_RUN);
        DIV_RN    = RN && (r_state != S_CLEAR);
        RSP_VALID = 2'b00;
        if (r_state == S_IDLE) begin
            case (REQ_VALID)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
            REQ_READY = w_grant;
        end
        if (r_state == S_RESP) begin
            RSP_VALID = r_owner ? 2'b10 : 2'b01;
        end
    end

    assign w_accept = |(w_grant & REQ_VALID);

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_div_a  <= '0;
            r_div_b  <= '0;
            r_rsp_q  <= '0;
            r_rsp_r  <= '0;
            r_rsp_dz <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_div_a <= w_sel_a;
                r_div_b <= w_sel_b;
                r_owner <= w_grant[1];
                r_last  <= w_grant[1];
                if (w_sel_b == '0) begin
                    r_rsp_q  <= '1;
                    r_rsp_r  <= w_sel_a;
                    r_rsp_dz <= 1'b1;
                end
            end
            if (r_state == S_CLEAR) begin
                r_cnt <= '0;
            end
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_CAPT) begin
                r_rsp_q  <= DIV_Q;
                r_rsp_r  <= DIV_R;
                r_rsp_dz <= 1'b0;
            end
        end
    end

    assign DIV_A  = r_div_a;
    assign DIV_B  = r_div_b;
    assign RSP_Q  = r_rsp_q;
    assign RSP_R  = r_rsp_r;
    assign RSP_DZ = r_rsp_dz;

endmodule
`default_nettype wire
